// File: rtl/cdc_evt_arb.sv
// Asynchronous edge-event collector: per-line synchroniser and edge detector, pending/overflow
// bookkeeping, and a round-robin arbiter driving one valid/ready port with a source id.

module cdc_sync_det #(
  parameter int STAGE = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic dat_i,
  output logic dat_pre_o,
  output logic dat_o
);

  logic [STAGE-1:0] sync_r;

  // Shift register synchroniser; the last two taps feed the edge detector
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_r <= {STAGE{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGE-2:0], dat_i};
    end
  end

  assign dat_pre_o = sync_r[STAGE-2];
  assign dat_o     = sync_r[STAGE-1];

endmodule

module cdc_evt_arb #(
  parameter int  NUM_REQ  = 4,
  parameter int  STAGE    = 2,
  parameter int  DET_MODE = 0,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] async_req_i,
  input  logic [NUM_REQ-1:0] en_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [ID_W-1:0]    evt_id_o,
  output logic [NUM_REQ-1:0] pend_o,
  output logic [NUM_REQ-1:0] ovf_o,
  input  logic               ovf_clr_i
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic               evt_valid_r, valid_nxt_s;
  logic [ID_W-1:0]    evt_id_r, id_nxt_s;
  logic [ID_W-1:0]    ptr_r, ptr_nxt_s;
  logic [NUM_REQ-1:0] pend_r, pend_nxt_s;
  logic [NUM_REQ-1:0] ovf_r, ovf_nxt_s;
  logic [NUM_REQ-1:0] p_s, q_s, edge_s, set_s, clr_s;
  logic               hs_s, found_s;
  logic [ID_W-1:0]    cand_s;

  // Modular add so a non-power-of-2 NUM_REQ never yields an out-of-range id
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(off);
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
    cdc_sync_det #(.STAGE(STAGE)) u_sync (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .dat_i     (async_req_i[g]),
      .dat_pre_o (p_s[g]),
      .dat_o     (q_s[g])
    );
  end

  // Edge selection
  always_comb begin
    case (DET_MODE)
      32'sd0:  edge_s = p_s & ~q_s;
      32'sd1:  edge_s = ~p_s & q_s;
      32'sd2:  edge_s = p_s ^ q_s;
      default: edge_s = p_s & ~q_s;
    endcase
  end

  // Pending/overflow update; a same-cycle new edge beats the handshake clear
  always_comb begin
    hs_s  = evt_valid_r & evt_ready_i;
    set_s = edge_s & en_i;
    clr_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      clr_s[i] = hs_s & (evt_id_r == ID_W'(i));
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
    ovf_nxt_s  = (ovf_clr_i ? {NUM_REQ{1'b0}} : ovf_r) | (set_s & pend_r & ~clr_s);
  end

  // Arbiter next state; IDLE searches upward from ptr with wrap
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = evt_valid_r;
    id_nxt_s    = evt_id_r;
    ptr_nxt_s   = ptr_r;
    found_s     = 1'b0;
    cand_s      = {ID_W{1'b0}};
    case (state_r)
      IDLE: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand_s = wrap_add(ptr_r, k);
          if (!found_s && pend_r[cand_s]) begin
            found_s  = 1'b1;
            id_nxt_s = cand_s;
          end else begin
            found_s  = found_s;
          end
        end
        if (found_s) begin
          valid_nxt_s = 1'b1;
          state_nxt_s = OFFER;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      OFFER: begin
        if (evt_ready_i) begin
          valid_nxt_s = 1'b0;
          ptr_nxt_s   = wrap_add(evt_id_r, 1);
          state_nxt_s = IDLE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= IDLE;
      evt_valid_r <= 1'b0;
      evt_id_r    <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
      pend_r      <= {NUM_REQ{1'b0}};
      ovf_r       <= {NUM_REQ{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      evt_valid_r <= valid_nxt_s;
      evt_id_r    <= id_nxt_s;
      ptr_r       <= ptr_nxt_s;
      pend_r      <= pend_nxt_s;
      ovf_r       <= ovf_nxt_s;
    end
  end

  assign evt_valid_o = evt_valid_r;
  assign evt_id_o    = evt_id_r;
  assign pend_o      = pend_r;
  assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_cdc_evt_arb.sv
// Directed bench for cdc_evt_arb: rising-edge instance for T1-T5, both-edge instance for T6.

module tb_cdc_evt_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] en;
  logic       ready;
  logic       ovf_clr;
  logic       valid, valid2;
  logic [1:0] id, id2;
  logic [3:0] pend, pend2, ovf, ovf2;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  cdc_evt_arb #(.NUM_REQ(4), .STAGE(2), .DET_MODE(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .async_req_i(req), .en_i(en),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_id_o(id),
    .pend_o(pend), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
  );

  cdc_evt_arb #(.NUM_REQ(4), .STAGE(2), .DET_MODE(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .async_req_i(req), .en_i(en),
    .evt_valid_o(valid2), .evt_ready_i(ready), .evt_id_o(id2),
    .pend_o(pend2), .ovf_o(ovf2), .ovf_clr_i(ovf_clr)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst_n   = 1'b0;
    req     = 4'b0000;
    en      = 4'b1111;
    ready   = rdy;
    ovf_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_id", id, 2'd0);
    chk("rst_pend", pend, 4'b0000);
    chk("rst_ovf", ovf, 4'b0000);

    // T1: single rising edge on line 2
    req = 4'b0100;
    tick(1);
    chk("t1_pend_e1", pend, 4'b0000);
    tick(1);
    chk("t1_pend_e2", pend, 4'b0100);
    chk("t1_valid_e2", valid, 1'b0);
    tick(1);
    chk("t1_valid_e3", valid, 1'b1);
    chk("t1_id_e3", id, 2'd2);
    tick(1);
    chk("t1_pend_hs", pend, 4'b0000);
    chk("t1_valid_hs", valid, 1'b0);
    req = 4'b0000;
    tick(3);
    chk("t1_no_fall_evt", valid, 1'b0);

    // T2: lines 0,1,3 together, round-robin order 0,1,3 with bubbles
    do_reset(1'b1);
    req = 4'b1011;
    tick(2);
    chk("t2_pend", pend, 4'b1011);
    tick(1);
    chk("t2_v0", valid, 1'b1);
    chk("t2_id0", id, 2'd0);
    tick(1);
    chk("t2_bub0", valid, 1'b0);
    chk("t2_pend_a", pend, 4'b1010);
    tick(1);
    chk("t2_v1", valid, 1'b1);
    chk("t2_id1", id, 2'd1);
    tick(1);
    chk("t2_bub1", valid, 1'b0);
    tick(1);
    chk("t2_v3", valid, 1'b1);
    chk("t2_id3", id, 2'd3);
    tick(1);
    chk("t2_end_valid", valid, 1'b0);
    chk("t2_end_pend", pend, 4'b0000);
    // ptr wrapped to 0: a fresh edge on lines 0 and 3 must issue id 0 first
    req = 4'b0000;
    tick(2);
    req = 4'b1001;
    tick(3);
    chk("t2_ptr0_id", id, 2'd0);
    chk("t2_ptr0_v", valid, 1'b1);

    // T3: overflow while id 1 is held
    do_reset(1'b0);
    req = 4'b0010;
    tick(3);
    chk("t3_v", valid, 1'b1);
    chk("t3_id", id, 2'd1);
    req = 4'b0000;
    tick(2);
    req = 4'b0010;
    tick(2);
    chk("t3_ovf", ovf, 4'b0010);
    chk("t3_id_hold", id, 2'd1);
    chk("t3_v_hold", valid, 1'b1);
    chk("t3_pend", pend, 4'b0010);
    ready = 1'b1;
    tick(1);
    chk("t3_pend_hs", pend, 4'b0000);
    tick(3);
    chk("t3_single_evt", valid, 1'b0);
    chk("t3_ovf_sticky", ovf, 4'b0010);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf, 4'b0000);

    // T4: new edge coincides with the id 1 handshake
    do_reset(1'b0);
    req = 4'b0010;
    tick(3);
    chk("t4_v", valid, 1'b1);
    req = 4'b0000;
    tick(2);
    req = 4'b0010;
    tick(1);
    ready = 1'b1;
    tick(1);
    chk("t4_pend_keep", pend, 4'b0010);
    chk("t4_no_ovf", ovf, 4'b0000);
    chk("t4_bubble", valid, 1'b0);
    tick(1);
    chk("t4_v2", valid, 1'b1);
    chk("t4_id2", id, 2'd1);
    tick(1);
    chk("t4_pend_done", pend, 4'b0000);

    // T5: enable masking
    do_reset(1'b1);
    en  = 4'b1110;
    req = 4'b0001;
    tick(4);
    chk("t5_mask_pend", pend, 4'b0000);
    chk("t5_mask_v", valid, 1'b0);
    do_reset(1'b0);
    req = 4'b0001;
    tick(2);
    chk("t5_pend", pend, 4'b0001);
    en = 4'b1110;
    tick(1);
    chk("t5_v_after_dis", valid, 1'b1);
    chk("t5_id", id, 2'd0);
    ready = 1'b1;
    tick(1);
    chk("t5_delivered", pend, 4'b0000);

    // T6: both-edge mode and asynchronous reset mid-offer
    do_reset(1'b1);
    req = 4'b1000;
    tick(3);
    chk("t6_v_rise", valid2, 1'b1);
    chk("t6_id_rise", id2, 2'd3);
    req = 4'b0000;
    tick(2);
    chk("t6_pend_fall", pend2, 4'b1000);
    ready = 1'b0;
    tick(1);
    chk("t6_v_fall", valid2, 1'b1);
    chk("t6_id_fall", id2, 2'd3);
    chk("t6_rise_only", pend, 4'b0000);
    tick(1);
    chk("t6_offer_hold", valid2, 1'b1);
    req   = 4'b0110;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", valid2, 1'b0);
    chk("t6_rst_id", id2, 2'd0);
    chk("t6_rst_pend", pend2, 4'b0000);
    chk("t6_rst_ovf", ovf2, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
